// File: rtl/eth_tx_sched_if.sv
// rtl/eth_tx_sched_if.sv - request/grant and transmitter-control bundle for eth_tx_sched
interface eth_tx_sched_if #(
    parameter int N_REQ = 2,
    parameter int SEL_W = 1
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic             start;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic             nlp;

    // Scheduler side: consumes requests, drives transmitter control
    modport master (
        input  req,
        output grant, start, sel, busy, done, nlp
    );

    // Frame sources / transmitter side
    modport slave (
        output req,
        input  grant, start, sel, busy, done, nlp
    );
endinterface

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - round-robin 10BASE-T transmit scheduler with frame/IFG timing and link pulses
module eth_tx_sched #(
    parameter int N_REQ        = 2,
    parameter int SEL_W        = 1,
    parameter int FRAME_CYCLES = 1200,
    parameter int IFG_CYCLES   = 96,
    parameter int NLP_PERIOD   = 160000
) (
    input  logic           clk,
    input  logic           rst_n,
    eth_tx_sched_if.master bus
);

    // One counter serves both the frame and the gap, so size it for the longer
    localparam int CNT_MAX = (FRAME_CYCLES > IFG_CYCLES) ? FRAME_CYCLES : IFG_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int NLP_W   = (NLP_PERIOD > 1) ? $clog2(NLP_PERIOD) : 1;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] IFG_LAST   = CNT_W'(IFG_CYCLES - 1);
    localparam logic [NLP_W-1:0] NLP_LAST   = NLP_W'(NLP_PERIOD - 1);
    localparam logic [SEL_W-1:0] PTR_RESET  = SEL_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_IFG  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NLP_W-1:0] nlp_cnt_q, nlp_cnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             nlp_q, nlp_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    int               cand;

    // Round-robin pick: first requester strictly after the pointer, wrapping around
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(ptr_q) + i) % N_REQ;
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = SEL_W'(cand);
            end
        end
    end

    // Next-state and registered-output computation for IDLE / TX / IFG
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nlp_cnt_d = nlp_cnt_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        grant_d   = '0;
        start_d   = 1'b0;
        done_d    = 1'b0;
        nlp_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Link pulse takes precedence over a frame; the gap after it keeps pulses apart from frames
                if (nlp_cnt_q == NLP_LAST) begin
                    nlp_d     = 1'b1;
                    nlp_cnt_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_IFG;
                end else if (pick_found) begin
                    start_d   = 1'b1;
                    grant_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    sel_d     = pick_idx;
                    ptr_d     = pick_idx;
                    cnt_d     = '0;
                    nlp_cnt_d = '0;
                    state_d   = ST_TX;
                end else begin
                    nlp_cnt_d = nlp_cnt_q + 1'b1;
                end
            end
            ST_TX: begin
                if (cnt_q == FRAME_LAST) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IFG;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IFG: begin
                nlp_cnt_d = '0;
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            nlp_cnt_q <= '0;
            ptr_q     <= PTR_RESET;
            sel_q     <= '0;
            grant_q   <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nlp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nlp_cnt_q <= nlp_cnt_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            nlp_q     <= nlp_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.start = start_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.nlp   = nlp_q;

endmodule
